// File: rtl/fpu_sched.sv
// ---------------------------------------------------------------------------
// fpu_sched
//
// Two-requester scheduler for the shared single-precision FPU core.
// A round-robin arbiter picks one request, its operands and op code are
// latched, and the core gets a single start pulse. The scheduler then waits
// for the core's done strobe under a watchdog. It hands the result back to
// the requester that owns the operation over a valid/ack handshake. Only one
// operation is in flight at a time.
//
// Parameters
//   TIMEOUT      maximum number of WAIT cycles before the watchdog fires
//                (legal range 1..255)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   req0_* / req1_*            request channels: valid/ready, operands a/b, op
//   core_start                 one-cycle start pulse to the FPU core
//   core_a, core_b, core_op    latched operands and op code for the core
//   core_done, core_c,         result strobe, packed result word and
//   core_flag                  exception flag from the core
//   rsp0_valid / rsp1_valid    response pending for that requester
//   rsp0_ack / rsp1_ack        requester consumes its response
//   rsp_c, rsp_flag, rsp_err   shared response word, exception flag and
//                              watchdog marker
//   busy                       high whenever the scheduler is not idle
// ---------------------------------------------------------------------------
module fpu_sched #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [1:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [1:0]  req1_op,
  output logic        core_start,
  output logic [31:0] core_a,
  output logic [31:0] core_b,
  output logic [1:0]  core_op,
  input  logic        core_done,
  input  logic [31:0] core_c,
  input  logic        core_flag,
  output logic        rsp0_valid,
  input  logic        rsp0_ack,
  output logic        rsp1_valid,
  input  logic        rsp1_ack,
  output logic [31:0] rsp_c,
  output logic        rsp_flag,
  output logic        rsp_err,
  output logic        busy
);

  // Last WAIT cycle index; the watchdog fires when the timer reaches it.
  localparam logic [7:0]  TMAX     = 8'(TIMEOUT - 1);
  // Quiet NaN returned when the watchdog fires.
  localparam logic [31:0] QNAN_VAL = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  timer;
  logic        owner;
  logic        last_grant;
  logic        grant0, grant1;
  logic        accept;
  logic        owner_ack;
  logic        timed_out;

  // Round-robin grant: on a tie the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant) grant0 = 1'b1;
      else            grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign accept    = (state == IDLE) && (grant0 || grant1);
  assign owner_ack = owner ? rsp1_ack : rsp0_ack;
  assign timed_out = (timer == TMAX);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (accept) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (core_done || timed_out) state_nxt = RESP;
      RESP:  if (owner_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode. Ready is the only combinational path from the inputs;
  // it is also held low while reset is asserted so every output reads 0.
  always_comb begin
    req0_ready = rst_n && (state == IDLE) && grant0;
    req1_ready = rst_n && (state == IDLE) && grant1;
    core_start = (state == ISSUE);
    busy       = (state != IDLE);
    rsp0_valid = (state == RESP) && !owner;
    rsp1_valid = (state == RESP) &&  owner;
  end

  // Operand latch and ownership, captured on the accepting cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_a  <= '0;
      core_b  <= '0;
      core_op <= '0;
      owner   <= 1'b0;
    end else if (accept) begin
      core_a  <= grant1 ? req1_a  : req0_a;
      core_b  <= grant1 ? req1_b  : req0_b;
      core_op <= grant1 ? req1_op : req0_op;
      owner   <= grant1;
    end
  end

  // Watchdog timer and result capture. A done strobe outside WAIT is
  // ignored; inside WAIT it takes priority over the watchdog.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer    <= '0;
      rsp_c    <= '0;
      rsp_flag <= 1'b0;
      rsp_err  <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        timer <= '0;
      end else if (state == WAIT) begin
        if (core_done) begin
          rsp_c    <= core_c;
          rsp_flag <= core_flag;
          rsp_err  <= 1'b0;
        end else if (timed_out) begin
          rsp_c    <= QNAN_VAL;
          rsp_flag <= 1'b1;
          rsp_err  <= 1'b1;
        end else begin
          timer <= timer + 8'd1;
        end
      end
    end
  end

  // Fairness history: only a completed hand-back updates it. After reset
  // last_grant=1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         last_grant <= 1'b1;
    else if (state == RESP && owner_ack) last_grant <= owner;
  end

endmodule

// File: tb/tb_fpu_sched.sv
// ---------------------------------------------------------------------------
// tb_fpu_sched
//
// Directed testbench for fpu_sched. Inputs change on the falling clock
// edge; outputs are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fpu_sched;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        core_start;
  logic [31:0] core_a, core_b;
  logic [1:0]  core_op;
  logic        core_done;
  logic [31:0] core_c;
  logic        core_flag;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ack, rsp1_ack;
  logic [31:0] rsp_c;
  logic        rsp_flag, rsp_err;
  logic        busy;

  int checks;
  int errors;

  fpu_sched #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .core_start (core_start),
    .core_a     (core_a),
    .core_b     (core_b),
    .core_op    (core_op),
    .core_done  (core_done),
    .core_c     (core_c),
    .core_flag  (core_flag),
    .rsp0_valid (rsp0_valid),
    .rsp0_ack   (rsp0_ack),
    .rsp1_valid (rsp1_valid),
    .rsp1_ack   (rsp1_ack),
    .rsp_c      (rsp_c),
    .rsp_flag   (rsp_flag),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    checks++;
    if ({busy, core_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_flag, rsp_err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 00000000",
               {busy, core_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_flag, rsp_err});
    end
    checks++;
    if ({core_a, core_b, core_op, rsp_c} !== 98'b0) begin
      errors++;
      $display("FAIL reset_data got a=%h b=%h op=%h c=%h exp all 0", core_a, core_b, core_op, rsp_c);
    end
    req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; req0_op = 2'd0;
    #1;
    checks++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      errors++; $display("FAIL single_ready got %b exp 10", {req0_ready, req1_ready});
    end
    @(negedge clk);  // T+1
    req0_valid = 1'b0;
    #1;
    checks++;
    if (core_start !== 1'b1 || core_a !== 32'h3F80_0000 || core_b !== 32'h4000_0000 || core_op !== 2'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got start=%b a=%h b=%h op=%0d busy=%b exp 1 3f800000 40000000 0 1",
               core_start, core_a, core_b, core_op, busy);
    end
    @(negedge clk);  // T+2
    #1;
    checks++;
    if (core_start !== 1'b0) begin
      errors++; $display("FAIL single_start_once got %b exp 0", core_start);
    end
    @(negedge clk);  // T+3
    @(negedge clk);  // T+4
    core_done = 1'b1; core_c = 32'h4040_0000; core_flag = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_early_valid got %b exp 0", rsp0_valid);
    end
    @(negedge clk);  // T+5
    core_done = 1'b0; rsp0_ack = 1'b1;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_c !== 32'h4040_0000 || rsp_err !== 1'b0 || rsp_flag !== 1'b0) begin
      errors++;
      $display("FAIL single_resp got v0=%b v1=%b c=%h err=%b flag=%b exp 1 0 40400000 0 0",
               rsp0_valid, rsp1_valid, rsp_c, rsp_err, rsp_flag);
    end
    @(negedge clk);  // T+6
    rsp0_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle got busy=%b v0=%b exp 0 0", busy, rsp0_valid);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    req0_a = 32'h1111_1111; req0_b = 32'h0; req0_op = 2'd1;
    req1_a = 32'h2222_2222; req1_b = 32'h0; req1_op = 2'd2;
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic e;
      e = i[0];
      #1;
      checks++;
      if ({req1_ready, req0_ready} !== (e ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant%0d got r1r0=%b exp grant %0d", i, {req1_ready, req0_ready}, e);
      end
      @(negedge clk);
      #1;
      checks++;
      if (core_start !== 1'b1 || core_a !== (e ? 32'h2222_2222 : 32'h1111_1111) || core_op !== (e ? 2'd2 : 2'd1)) begin
        errors++; $display("FAIL rr_issue%0d got start=%b a=%h op=%0d exp owner %0d", i, core_start, core_a, core_op, e);
      end
      @(negedge clk);
      core_done = 1'b1; core_c = 32'hC000_0000 + 32'(i); core_flag = 1'b0;
      @(negedge clk);
      core_done = 1'b0;
      if (e) rsp1_ack = 1'b1;
      else   rsp0_ack = 1'b1;
      #1;
      checks++;
      if ({rsp1_valid, rsp0_valid} !== (e ? 2'b10 : 2'b01) || rsp_c !== 32'hC000_0000 + 32'(i)) begin
        errors++; $display("FAIL rr_resp%0d got v1v0=%b c=%h exp owner %0d c=%h", i, {rsp1_valid, rsp0_valid}, rsp_c, e, 32'hC000_0000 + 32'(i));
      end
      @(negedge clk);
      rsp0_ack = 1'b0; rsp1_ack = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_timeout();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h4120_0000; req1_b = 32'h0; req1_op = 2'd3;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL to_ready got %b exp 1", req1_ready);
    end
    @(negedge clk);  // T+1
    req1_valid = 1'b0;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      #1;
      checks++;
      if (rsp1_valid !== 1'b0) begin
        errors++; $display("FAIL to_early_T+%0d got %b exp 0", k, rsp1_valid);
      end
    end
    @(negedge clk);  // T+17
    rsp1_ack = 1'b1;
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0 || rsp_c !== 32'h7FC0_0000 || rsp_flag !== 1'b1 || rsp_err !== 1'b1) begin
      errors++;
      $display("FAIL to_resp got v1=%b v0=%b c=%h flag=%b err=%b exp 1 0 7fc00000 1 1",
               rsp1_valid, rsp0_valid, rsp_c, rsp_flag, rsp_err);
    end
    @(negedge clk);
    rsp1_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL to_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_done_last_wait();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h4080_0000;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL lw_ready got %b exp 1", req0_ready);
    end
    @(negedge clk);  // T+1
    req0_valid = 1'b0;
    for (int k = 2; k <= 15; k++) @(negedge clk);
    @(negedge clk);  // T+16, timer=14
    core_done = 1'b1; core_c = 32'h1234_5678; core_flag = 1'b1;
    @(negedge clk);  // T+17, spurious done in RESP
    core_done = 1'b1; core_c = 32'hDEAD_BEEF; core_flag = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_c !== 32'h1234_5678 || rsp_flag !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_resp got v0=%b c=%h flag=%b err=%b exp 1 12345678 1 0", rsp0_valid, rsp_c, rsp_flag, rsp_err);
    end
    @(negedge clk);
    core_done = 1'b0; rsp0_ack = 1'b1;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_c !== 32'h1234_5678 || rsp_flag !== 1'b1) begin
      errors++; $display("FAIL lw_spur_resp got v0=%b c=%h flag=%b exp 1 12345678 1", rsp0_valid, rsp_c, rsp_flag);
    end
    @(negedge clk);  // IDLE, spurious done
    rsp0_ack = 1'b0; core_done = 1'b1; core_c = 32'hABCD_ABCD;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL lw_idle got busy=%b exp 0", busy);
    end
    @(negedge clk);
    core_done = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || core_start !== 1'b0 || rsp_c !== 32'h1234_5678) begin
      errors++; $display("FAIL lw_spur_idle got busy=%b start=%b c=%h exp 0 0 12345678", busy, core_start, rsp_c);
    end
  endtask

  task automatic test_hold_ack();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h3333_3333;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL hold_ready got %b exp 1", req0_ready);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    core_done = 1'b1; core_c = 32'h5555_5555; core_flag = 1'b0;
    @(negedge clk);
    core_done = 1'b0; req1_valid = 1'b1; req1_a = 32'h4444_4444;
    #1;
    checks++;
    if (rsp0_valid !== 1'b1 || rsp_c !== 32'h5555_5555) begin
      errors++; $display("FAIL hold_resp got v0=%b c=%h exp 1 55555555", rsp0_valid, rsp_c);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      rsp1_ack = k[0];
      #1;
      checks++;
      if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0 || rsp_c !== 32'h5555_5555 || req1_ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL hold_stable%0d got v0=%b v1=%b c=%h r1=%b busy=%b exp 1 0 55555555 0 1",
                 k, rsp0_valid, rsp1_valid, rsp_c, req1_ready, busy);
      end
    end
    @(negedge clk);
    rsp1_ack = 1'b0; rsp0_ack = 1'b1;
    @(negedge clk);
    rsp0_ack = 1'b0;
    #1;
    checks++;
    if (req1_ready !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL hold_release got r1=%b busy=%b exp 1 0", req1_ready, busy);
    end
    req1_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h7777_7777; req0_b = 32'h7676_7676; req0_op = 2'd3;
    #1;
    checks++;
    if (req0_ready !== 1'b1) begin
      errors++; $display("FAIL rm_ready got %b exp 1", req0_ready);
    end
    @(negedge clk);  // ISSUE
    req0_valid = 1'b0;
    @(negedge clk);  // WAIT
    #1;
    checks++;
    if (busy !== 1'b1 || core_a !== 32'h7777_7777) begin
      errors++; $display("FAIL rm_wait got busy=%b a=%h exp 1 77777777", busy, core_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, core_start, rsp0_valid, rsp1_valid, req0_ready, req1_ready, rsp_flag, rsp_err} !== 8'b0 ||
        {core_a, core_b, core_op, rsp_c} !== 98'b0) begin
      errors++;
      $display("FAIL rm_async got busy=%b a=%h b=%h op=%0d c=%h exp all 0", busy, core_a, core_b, core_op, rsp_c);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_done = 1'b1; core_c = 32'h9999_9999;
    @(negedge clk);
    core_done = 1'b0;
    #1;
    checks++;
    if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 || rsp_c !== 32'h0) begin
      errors++; $display("FAIL rm_late_done got v0=%b v1=%b busy=%b c=%h exp 0 0 0 0", rsp0_valid, rsp1_valid, busy, rsp_c);
    end
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 32'h8888_8888;
    #1;
    checks++;
    if (req1_ready !== 1'b1) begin
      errors++; $display("FAIL rm_new_ready got %b exp 1", req1_ready);
    end
    @(negedge clk);
    req1_valid = 1'b0;
    #1;
    checks++;
    if (core_start !== 1'b1 || core_a !== 32'h8888_8888) begin
      errors++; $display("FAIL rm_new_issue got start=%b a=%h exp 1 88888888", core_start, core_a);
    end
    @(negedge clk);
    core_done = 1'b1; core_c = 32'h6666_6666; core_flag = 1'b0;
    @(negedge clk);
    core_done = 1'b0; rsp1_ack = 1'b1;
    #1;
    checks++;
    if (rsp1_valid !== 1'b1 || rsp_c !== 32'h6666_6666 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL rm_new_resp got v1=%b c=%h err=%b exp 1 66666666 0", rsp1_valid, rsp_c, rsp_err);
    end
    @(negedge clk);
    rsp1_ack = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rm_new_idle got busy=%b exp 0", busy);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    core_done = 1'b0; core_c = '0; core_flag = 1'b0;
    rsp0_ack = 1'b0; rsp1_ack = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_done_last_wait();
    test_hold_ack();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
